pdh_sample_decimator: RTL
=========================

# pdh_sample_decimator

Front-end producer for `pid_core`. It accepts the per-clock signed error samples, boxcar-averages them over a programmable window, and drives the controller's `dat_i`/`strobe_i` pair. Each output is a saturated 16-bit word with a one-cycle strobe, one per window. It sits between the demodulated ADC stream and `pid_core`, and generates the strobe cadence the loop filter runs on.

## Interface
- `DAT_W`, default 16: signed sample width for both input and output.
- `DEC_W`, default 14: width of the window-length control.
- `ACC_W`, default `DAT_W+DEC_W+1`: accumulator width. It must not overflow for any legal window.
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-low: registers clear while `rst`==0.
- `clk` in, 1: system clock, all logic on rising edge.
- `rst` in, 1: asynchronous, active-low reset.
- `enable_i` in, 1: run enable. Low clears the window in progress.
- `sample_i` in, DAT_W, signed: input error sample.
- `valid_i` in, 1: `sample_i` is valid this cycle. Gaps are allowed.
- `decimate_i` in, DEC_W: window length N. Values 0 and 1 both mean pass-through, i.e. N=1.
- `shift_i` in, 4: arithmetic right shift applied to the window sum.
- `dat_o` out, DAT_W, signed: averaged, saturated result. Holds its value between strobes.
- `strobe_o` out, 1: one-cycle pulse, `dat_o` is new. Connects to `pid_core` `strobe_i`.
- `sat_o` out, 1: high with `strobe_o` when the result was clamped.

## Operation
- States:
  - IDLE: `enable_i`=0. Accumulator and counter are held at 0.
  - ACCUM: `enable_i`=1.
- Transitions: IDLE→ACCUM on `enable_i`=1. Any state→IDLE on `enable_i`=0 in the same cycle. The partial window is discarded and no strobe is issued.
- Window length latching:
  - N_lat is taken from `decimate_i` on the first valid sample of each window (counter==0), with 0 mapped to 1.
  - A change to `decimate_i` mid-window takes effect on the next window.
- Each valid sample: `acc += sign_extend(sample_i)` and `cnt++`.
- On the valid sample with `cnt`==N_lat−1:
  - `sum = acc + sample_i`.
  - `res = sum >>> shift_i` (arithmetic shift).
  - Clamp to [−2^(DAT_W−1), 2^(DAT_W−1)−1].
  - Register the result into `dat_o`, pulse `strobe_o`, and set `sat_o` if clamped.
  - Clear `acc` and `cnt` in the same cycle, so back-to-back windows lose no sample.
- Invalid cycles (`valid_i`=0) change nothing. The window counts valid samples, not clocks.
- `shift_i` is sampled on the completing sample only.
- `enable_i` falling in the same cycle as a completing sample: enable wins, and no strobe is issued.

## Timing
- Reset values: `dat_o`=0, `strobe_o`=0, `sat_o`=0, `acc`=0, `cnt`=0, state IDLE.
- Latency: `strobe_o`/`dat_o` update on the clock edge that captures the N-th valid sample. The strobe is visible in the following cycle, i.e. one register stage.
- `strobe_o` is high for exactly one cycle per completed window. There are never two consecutive strobes unless N=1 with continuous `valid_i`.
- N=1 with continuous valid gives a strobe every cycle, with `dat_o` = clamp(`sample_i` >>> `shift_i`) delayed by one cycle.
- Reset asserted mid-window: everything clears asynchronously. After release, the first window starts at the next valid sample.

## Structure
- Shared package `pdh_pkg` holds:
  - Constants `DAT_W`, `DEC_W`, `ACC_W`.
  - State enum `dec_state_t {IDLE, ACCUM}`.
  - Function `sat_to_dat(logic signed [ACC_W-1:0])`, which returns the clamped value and the overflow flag.
- One sub-module: `pdh_sat_shift`, a combinational shift-then-clamp block also reusable on the `pid_core` output path.

## Test plan
- Window average: N=4, `shift_i`=2, `sample_i`=8192 constant, `valid_i`=1 → strobe every 4th cycle, `dat_o`=8192, `sat_o`=0.
- Positive saturation: N=16, `shift_i`=0, `sample_i`=32767 → `dat_o`=32767, `sat_o`=1. With `sample_i`=−8192 → `dat_o`=−32768, `sat_o`=1.
- Gapped valid: N=3, `shift_i`=0, samples 10, 20, −5 interleaved with idle cycles → single strobe after the 3rd valid sample, `dat_o`=25.
- Mid-window changes:
  - Drop `enable_i` after 2 of 4 samples, then re-enable → no strobe for the partial window. The next strobe covers 4 fresh samples.
  - Change `decimate_i` 4→2 mid-window → current window still completes at 4, next windows at 2.
- Reset: assert `rst`=0 mid-window with `dat_o`=100 → `dat_o`, `strobe_o`, `sat_o` read 0 immediately. After release, the first strobe appears after N fresh samples.
- Pass-through: `decimate_i`=0, `shift_i`=0, ramp input → `strobe_o` every valid cycle, `dat_o` equals the input delayed one cycle.

Source files
------------

// File: rtl/pdh_pkg.sv
// Shared types, widths and the saturation helper for the PDH error-signal path.
// Used by the decimator front end and reusable on the pid_core output path.
package pdh_pkg;

  localparam int DAT_W = 16;
  localparam int DEC_W = 14;
  localparam int ACC_W = DAT_W + DEC_W + 1;

  typedef enum logic {
    IDLE,
    ACCUM
  } dec_state_t;

  typedef struct packed {
    logic signed [DAT_W-1:0] dat;
    logic                    ovf;
  } sat_res_t;

  // Clamp a full-width value into the DAT_W signed range.
  // The value fits only when all bits above the output sign bit equal that sign bit.
  function automatic sat_res_t sat_to_dat(input logic signed [ACC_W-1:0] v);
    sat_res_t             r;
    logic [ACC_W-DAT_W:0] top;
    top = v[ACC_W-1:DAT_W-1];
    if ((&top) || !(|top)) begin
      r.dat = v[DAT_W-1:0];
      r.ovf = 1'b0;
    end else begin
      r.dat = v[ACC_W-1] ? {1'b1, {(DAT_W-1){1'b0}}} : {1'b0, {(DAT_W-1){1'b1}}};
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pdh_sat_shift.sv
// Combinational arithmetic right shift followed by a clamp to DAT_W signed.
// Shared between the decimator output and the pid_core output path.
module pdh_sat_shift #(
  parameter int DAT_W = pdh_pkg::DAT_W,
  parameter int ACC_W = pdh_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0] sum_i,
  input  logic        [3:0]       shift_i,
  output logic signed [DAT_W-1:0] dat_o,
  output logic                    sat_o
);

  import pdh_pkg::sat_res_t;
  import pdh_pkg::sat_to_dat;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum_i >>> shift_i;
  end

  // Package widths use the shared helper; other widths get an equivalent local clamp.
  if (DAT_W == pdh_pkg::DAT_W && ACC_W == pdh_pkg::ACC_W) begin : g_pkg
    sat_res_t res;
    always_comb begin
      res   = sat_to_dat(shifted);
      dat_o = res.dat;
      sat_o = res.ovf;
    end
  end else begin : g_gen
    logic [ACC_W-DAT_W:0] top;
    always_comb begin
      top   = shifted[ACC_W-1:DAT_W-1];
      dat_o = shifted[DAT_W-1:0];
      sat_o = 1'b0;
      if (!((&top) || !(|top))) begin
        sat_o = 1'b1;
        dat_o = shifted[ACC_W-1] ? {1'b1, {(DAT_W-1){1'b0}}} : {1'b0, {(DAT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/pdh_sample_decimator.sv
// Boxcar decimator: averages N valid error samples, shifts, clamps and strobes
// one result per window into pid_core's dat_i/strobe_i.
module pdh_sample_decimator #(
  parameter int DAT_W = 16,
  parameter int DEC_W = 14,
  parameter int ACC_W = DAT_W + DEC_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic signed [DAT_W-1:0] sample_i,
  input  logic                    valid_i,
  input  logic        [DEC_W-1:0] decimate_i,
  input  logic        [3:0]       shift_i,
  output logic signed [DAT_W-1:0] dat_o,
  output logic                    strobe_o,
  output logic                    sat_o
);

  import pdh_pkg::dec_state_t;
  import pdh_pkg::IDLE;
  import pdh_pkg::ACCUM;

  dec_state_t state, state_nxt;

  logic        [DEC_W-1:0] cnt;
  logic        [DEC_W-1:0] n_lat;
  logic        [DEC_W-1:0] n_cur;
  logic                    take;
  logic                    clr;
  logic                    last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [DAT_W-1:0] res_dat;
  logic                    res_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Enable is acted on in the same cycle it changes, so a rising enable
  // already accepts that cycle's sample and a falling one discards it.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_nxt = ACCUM;
          take      = valid_i;
        end else begin
          clr = 1'b1;
        end
      end
      ACCUM: begin
        if (!enable_i) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else begin
          take = valid_i;
        end
      end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
    endcase
  end

  // Window length is live from decimate_i only on the first sample of a window.
  always_comb begin
    if (cnt == '0) begin
      n_cur = (decimate_i == '0) ? DEC_W'(1) : decimate_i;
    end else begin
      n_cur = n_lat;
    end
    last       = (cnt == n_cur - DEC_W'(1));
    sample_ext = {{(ACC_W-DAT_W){sample_i[DAT_W-1]}}, sample_i};
    sum        = acc + sample_ext;
  end

  pdh_sat_shift #(
    .DAT_W(DAT_W),
    .ACC_W(ACC_W)
  ) u_sat_shift (
    .sum_i  (sum),
    .shift_i(shift_i),
    .dat_o  (res_dat),
    .sat_o  (res_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      cnt      <= '0;
      n_lat    <= '0;
      dat_o    <= '0;
      strobe_o <= 1'b0;
      sat_o    <= 1'b0;
    end else begin
      strobe_o <= 1'b0;
      sat_o    <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        if (cnt == '0) begin
          n_lat <= n_cur;
        end
        if (last) begin
          dat_o    <= res_dat;
          strobe_o <= 1'b1;
          sat_o    <= res_sat;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + DEC_W'(1);
        end
      end
    end
  end

endmodule
